// File: rtl/counter_pkg.sv
// counter_pkg: shared direction/mode encodings and default sizes for prog_counter
package counter_pkg;
    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT = 1'b1;
    localparam int DEF_WIDTH = 10;
    localparam int DEF_PRESCALE_W = 8;
endpackage

// File: rtl/prog_prescaler.sv
// prog_prescaler: emits one tick every prescale+1 enabled cycles; frozen while en=0
module prog_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);
    localparam logic [PRESCALE_W-1:0] ONE = 1;
    logic [PRESCALE_W-1:0] cnt_d, cnt_q;
    assign tick = en && (cnt_q == prescale);
    always_comb cnt_d = (clr || tick) ? '0 : en ? cnt_q + ONE : cnt_q;
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/prog_counter.sv
// prog_counter: prescaled up/down counter bounded to 0..limit with wrap/saturate, tc pulse and sticky ovf
module prog_counter
    import counter_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int PRESCALE_W = DEF_PRESCALE_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  up_dn,
    input  logic                  sat_mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      limit,
    input  logic [PRESCALE_W-1:0] prescale,
    input  logic                  clr_ovf,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  ovf
);
    localparam logic [WIDTH-1:0] ONE = 1;
    logic             tick, bnd;
    logic [WIDTH-1:0] count_d, count_q;
    logic             tc_d, tc_q, ovf_d, ovf_q;
    prog_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );
    always_comb begin
        bnd = 1'b0;
        count_d = count_q;
        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
        end else if (tick && up_dn == DIR_UP) begin
            bnd = count_q >= limit;
            count_d = !bnd ? count_q + ONE : (sat_mode == MODE_SAT) ? limit : '0;
        end else if (tick) begin
            // a count stranded above a lowered limit snaps down to the limit
            bnd = count_q == '0;
            count_d = bnd ? ((sat_mode == MODE_SAT) ? '0 : limit)
                          : (count_q > limit) ? limit : count_q - ONE;
        end
        tc_d = bnd;
        ovf_d = bnd | (ovf_q & ~clr_ovf);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q <= tc_d;
            ovf_q <= ovf_d;
        end
    end
    assign count = count_q;
    assign tc = tc_q;
    assign ovf = ovf_q;
endmodule

// File: tb/tb_prog_counter.sv
// tb_prog_counter: table-driven vectors with an expected-result queue plus hand sequences for long runs
module tb_prog_counter;
    logic       clk = 1'b0;
    logic       reset, en, up_dn, sat_mode, load, clr_ovf;
    logic [9:0] load_val, limit, count;
    logic [7:0] prescale;
    logic       tc, ovf;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst, en, up, sat, ld, clr;
        logic [9:0] lv, lim;
        logic [7:0] ps;
        logic [9:0] ec;
        logic       etc, eo;
    } vec_t;
    typedef struct {
        logic [9:0] c;
        logic       t, o;
    } exp_t;

    vec_t tab[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(10), .PRESCALE_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .sat_mode (sat_mode),
        .load     (load),
        .load_val (load_val),
        .limit    (limit),
        .prescale (prescale),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    function automatic vec_t v(int r, int e, int u, int s, int l, int lv, int lim, int ps, int c,
                               int ec, int et, int eo);
        vec_t x;
        x.rst = 1'(r); x.en = 1'(e); x.up = 1'(u); x.sat = 1'(s); x.ld = 1'(l); x.clr = 1'(c);
        x.lv = 10'(lv); x.lim = 10'(lim); x.ps = 8'(ps);
        x.ec = 10'(ec); x.etc = 1'(et); x.eo = 1'(eo);
        return x;
    endfunction

    task automatic chk(string name, logic [11:0] act, logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got count=%0d tc=%0b ovf=%0b, want count=%0d tc=%0b ovf=%0b",
                     name, act[11:2], act[1], act[0], exp[11:2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(vec_t x, string name);
        exp_t e;
        reset = x.rst; en = x.en; up_dn = x.up; sat_mode = x.sat; load = x.ld;
        load_val = x.lv; limit = x.lim; prescale = x.ps; clr_ovf = x.clr;
        sb.push_back('{x.ec, x.etc, x.eo});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk(name, {count, tc, ovf}, {e.c, e.t, e.o});
    endtask

    initial begin
        int tcs;
        logic [9:0] mid;
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0; load = 1'b0;
        load_val = '0; limit = '0; prescale = '0; clr_ovf = 1'b0;
        // rst en up sat ld lv lim ps clr | count tc ovf
        tab.push_back(v(1,0,1,0,0,0,5,0,0, 0,0,0));
        for (int i = 1; i <= 5; i++) tab.push_back(v(0,1,1,1,0,0,5,0,0, i,0,0));
        for (int i = 0; i < 3; i++) tab.push_back(v(0,1,1,1,0,0,5,0,0, 5,1,1));
        tab.push_back(v(0,0,1,1,0,0,5,0,1, 5,0,0));
        tab.push_back(v(0,1,0,0,1,0,9,0,0, 0,0,0));
        tab.push_back(v(0,1,0,0,0,0,9,0,0, 9,1,1));
        tab.push_back(v(0,1,0,0,0,0,9,0,0, 8,0,1));
        tab.push_back(v(0,0,0,0,0,0,9,0,0, 8,0,1));
        tab.push_back(v(0,1,1,0,1,700,500,0,0, 500,0,1));
        tab.push_back(v(0,0,1,0,0,0,500,0,0, 500,0,1));
        tab.push_back(v(0,1,1,0,0,0,500,0,0, 0,1,1));
        tab.push_back(v(0,0,1,0,1,3,0,0,0, 0,0,1));
        tab.push_back(v(0,1,1,0,0,0,0,0,0, 0,1,1));
        tab.push_back(v(0,1,0,1,0,0,0,0,0, 0,1,1));
        tab.push_back(v(0,0,0,0,1,8,9,0,0, 8,0,1));
        tab.push_back(v(0,1,0,0,0,0,4,0,0, 4,0,1));
        tab.push_back(v(0,1,1,0,0,0,4,0,1, 0,1,1));
        tab.push_back(v(0,0,1,0,0,0,4,0,1, 0,0,0));
        tab.push_back(v(0,1,0,0,1,0,9,0,0, 0,0,0));
        tab.push_back(v(0,1,0,0,0,0,9,0,0, 9,1,1));
        tab.push_back(v(1,1,1,1,1,7,9,0,1, 0,0,0));
        foreach (tab[i]) apply(tab[i], $sformatf("row%0d", i));

        // full-range wrap at WIDTH=10
        apply(v(1,0,1,0,0,0,1023,0,0, 0,0,0), "wrap_reset");
        reset = 1'b0; en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0; limit = 10'd1023;
        tcs = 0;
        mid = '0;
        for (int i = 0; i < 1024; i++) begin
            @(posedge clk);
            #1;
            if (tc) tcs++;
            if (i == 1022) mid = count;
        end
        chk("wrap_top", {mid, 2'b00}, {10'd1023, 2'b00});
        chk("wrap_end", {count, tc, ovf}, {10'd0, 1'b1, 1'b1});
        chk("wrap_tc_pulses", 12'(tcs), 12'd1);

        // prescale=3 with an en=0 freeze mid-period
        apply(v(1,0,1,0,0,0,1023,3,0, 0,0,0), "ps_reset");
        for (int i = 1; i <= 8; i++) apply(v(0,1,1,0,0,0,1023,3,0, i/4,0,0), $sformatf("ps_run%0d", i));
        apply(v(0,1,1,0,0,0,1023,3,0, 2,0,0), "ps_pre1");
        apply(v(0,1,1,0,0,0,1023,3,0, 2,0,0), "ps_pre2");
        apply(v(0,0,1,0,0,0,1023,3,0, 2,0,0), "ps_frz1");
        apply(v(0,0,1,0,0,0,1023,3,0, 2,0,0), "ps_frz2");
        apply(v(0,1,1,0,0,0,1023,3,0, 2,0,0), "ps_resume1");
        apply(v(0,1,1,0,0,0,1023,3,0, 3,0,0), "ps_resume2");

        // reset at count=37 with the prescaler mid-period
        apply(v(0,1,0,0,1,0,1023,0,0, 0,0,0), "rst_load0");
        apply(v(0,1,0,0,0,0,1023,0,0, 1023,1,1), "rst_wrapdn");
        apply(v(0,0,1,0,1,37,1023,3,0, 37,0,1), "rst_load37");
        apply(v(0,1,1,0,0,0,1023,3,0, 37,0,1), "rst_mid1");
        apply(v(0,1,1,0,0,0,1023,3,0, 37,0,1), "rst_mid2");
        apply(v(1,1,1,0,0,0,1023,3,0, 0,0,0), "rst_pulse");
        for (int i = 1; i <= 4; i++) apply(v(0,1,1,0,0,0,1023,3,0, i/4,0,0), $sformatf("rst_after%0d", i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
